// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths, reset polarity and the EX/MEM bundle type.
package ex_mem_pkg;

    localparam int RegBus       = 32;
    localparam int RegAddrBus   = 5;
    localparam int AluOpBus     = 8;
    localparam int DoubleRegBus = 64;

    localparam logic RstEnable    = 1'b0;
    localparam logic RstDisable   = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [AluOpBus-1:0]   EXE_NOP_OP = 8'h00;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b00000;

    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     wdata;
        logic [RegBus-1:0]     hi;
        logic [RegBus-1:0]     lo;
        logic                  whilo;
        logic [AluOpBus-1:0]   aluop;
        logic [RegBus-1:0]     mem_addr;
        logic [RegBus-1:0]     reg2;
        logic                  cp0_we;
        logic [4:0]            cp0_waddr;
        logic [RegBus-1:0]     cp0_data;
        logic [RegBus-1:0]     excepttype;
        logic                  in_delayslot;
        logic [RegBus-1:0]     inst_addr;
    } ex_mem_t;

    // A bubble writes nothing and can never raise an exception.
    function automatic ex_mem_t bubble();
        ex_mem_t b;
        b              = '0;
        b.wd           = NOPRegAddr;
        b.wreg         = WriteDisable;
        b.whilo        = WriteDisable;
        b.cp0_we       = WriteDisable;
        b.aluop        = EXE_NOP_OP;
        b.excepttype   = ZeroWord;
        return b;
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX results into the EX/MEM register and their MEM-side copies.
interface ex_mem_if;
    import ex_mem_pkg::*;

    logic [RegAddrBus-1:0]   ex_wd;
    logic                    ex_wreg;
    logic [RegBus-1:0]       ex_wdata;
    logic [RegBus-1:0]       ex_hi;
    logic [RegBus-1:0]       ex_lo;
    logic                    ex_whilo;
    logic [AluOpBus-1:0]     ex_aluop;
    logic [RegBus-1:0]       ex_mem_addr;
    logic [RegBus-1:0]       ex_reg2;
    logic                    ex_cp0_reg_we;
    logic [4:0]              ex_cp0_reg_write_addr;
    logic [RegBus-1:0]       ex_cp0_reg_data;
    logic [RegBus-1:0]       ex_excepttype;
    logic                    ex_is_in_delayslot;
    logic [RegBus-1:0]       ex_current_inst_address;
    logic [DoubleRegBus-1:0] hilo_i;
    logic [1:0]              cnt_i;

    logic [RegAddrBus-1:0]   mem_wd;
    logic                    mem_wreg;
    logic [RegBus-1:0]       mem_wdata;
    logic [RegBus-1:0]       mem_hi;
    logic [RegBus-1:0]       mem_lo;
    logic                    mem_whilo;
    logic [AluOpBus-1:0]     mem_aluop;
    logic [RegBus-1:0]       mem_mem_addr;
    logic [RegBus-1:0]       mem_reg2;
    logic                    mem_cp0_reg_we;
    logic [4:0]              mem_cp0_reg_write_addr;
    logic [RegBus-1:0]       mem_cp0_reg_data;
    logic [RegBus-1:0]       mem_excepttype;
    logic                    mem_is_in_delayslot;
    logic [RegBus-1:0]       mem_current_inst_address;
    logic                    mem_valid;
    logic [DoubleRegBus-1:0] hilo_o;
    logic [1:0]              cnt_o;

    modport master (
        output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
        output ex_aluop, ex_mem_addr, ex_reg2,
        output ex_cp0_reg_we, ex_cp0_reg_write_addr, ex_cp0_reg_data,
        output ex_excepttype, ex_is_in_delayslot,
        output ex_current_inst_address, hilo_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
        input  mem_aluop, mem_mem_addr, mem_reg2,
        input  mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data,
        input  mem_excepttype, mem_is_in_delayslot,
        input  mem_current_inst_address, mem_valid, hilo_o, cnt_o
    );

    modport slave (
        input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
        input  ex_aluop, ex_mem_addr, ex_reg2,
        input  ex_cp0_reg_we, ex_cp0_reg_write_addr, ex_cp0_reg_data,
        input  ex_excepttype, ex_is_in_delayslot,
        input  ex_current_inst_address, hilo_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
        output mem_aluop, mem_mem_addr, mem_reg2,
        output mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data,
        output mem_excepttype, mem_is_in_delayslot,
        output mem_current_inst_address, mem_valid, hilo_o, cnt_o
    );

endinterface

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with bubble, hold and flush handling,
// plus the madd/msub partial-product and cycle-count feedback to EX.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic         flush,
    ex_mem_if.slave      bus
);

    ex_mem_t                 w_ex;
    ex_mem_t                 r_mem;
    logic                    r_valid;
    logic [DoubleRegBus-1:0] r_hilo;
    logic [1:0]              r_cnt;
    logic                    w_unused;

    assign w_unused = &{1'b0, stall[5], stall[2:0]};

    assign w_ex.wd           = bus.ex_wd;
    assign w_ex.wreg         = bus.ex_wreg;
    assign w_ex.wdata        = bus.ex_wdata;
    assign w_ex.hi           = bus.ex_hi;
    assign w_ex.lo           = bus.ex_lo;
    assign w_ex.whilo        = bus.ex_whilo;
    assign w_ex.aluop        = bus.ex_aluop;
    assign w_ex.mem_addr     = bus.ex_mem_addr;
    assign w_ex.reg2         = bus.ex_reg2;
    assign w_ex.cp0_we       = bus.ex_cp0_reg_we;
    assign w_ex.cp0_waddr    = bus.ex_cp0_reg_write_addr;
    assign w_ex.cp0_data     = bus.ex_cp0_reg_data;
    assign w_ex.excepttype   = bus.ex_excepttype;
    assign w_ex.in_delayslot = bus.ex_is_in_delayslot;
    assign w_ex.inst_addr    = bus.ex_current_inst_address;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            r_mem   <= '0;
            r_valid <= 1'b0;
            r_hilo  <= '0;
            r_cnt   <= 2'd0;
        end else if (stall[3] && !stall[4]) begin
            // EX stalls mid-madd: keep its first-cycle product alive.
            r_mem   <= bubble();
            r_valid <= 1'b0;
            r_hilo  <= bus.hilo_i;
            r_cnt   <= bus.cnt_i;
        end else if (!stall[3]) begin
            r_mem   <= w_ex;
            r_valid <= 1'b1;
            r_hilo  <= '0;
            r_cnt   <= 2'd0;
        end
    end

    assign bus.mem_wd                   = r_mem.wd;
    assign bus.mem_wreg                 = r_mem.wreg;
    assign bus.mem_wdata                = r_mem.wdata;
    assign bus.mem_hi                   = r_mem.hi;
    assign bus.mem_lo                   = r_mem.lo;
    assign bus.mem_whilo                = r_mem.whilo;
    assign bus.mem_aluop                = r_mem.aluop;
    assign bus.mem_mem_addr             = r_mem.mem_addr;
    assign bus.mem_reg2                 = r_mem.reg2;
    assign bus.mem_cp0_reg_we           = r_mem.cp0_we;
    assign bus.mem_cp0_reg_write_addr   = r_mem.cp0_waddr;
    assign bus.mem_cp0_reg_data         = r_mem.cp0_data;
    assign bus.mem_excepttype           = r_mem.excepttype;
    assign bus.mem_is_in_delayslot      = r_mem.in_delayslot;
    assign bus.mem_current_inst_address = r_mem.inst_addr;
    assign bus.mem_valid                = r_valid;
    assign bus.hilo_o                   = r_hilo;
    assign bus.cnt_o                    = r_cnt;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed vectors feed a scoreboard queue; a negedge monitor
// pops one expectation per clock and compares every output.
module tb_ex_mem;
    import ex_mem_pkg::*;

    typedef struct packed {
        ex_mem_t     m;
        logic        v;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } out_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    ex_mem_t     ex_v;
    logic [63:0] hilo_v;
    logic [1:0]  cnt_v;

    int checks   = 0;
    int failures = 0;

    out_t  exp_q[$];
    string name_q[$];
    out_t  last;

    ex_mem_if bus();

    ex_mem u_dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    assign bus.ex_wd                   = ex_v.wd;
    assign bus.ex_wreg                 = ex_v.wreg;
    assign bus.ex_wdata                = ex_v.wdata;
    assign bus.ex_hi                   = ex_v.hi;
    assign bus.ex_lo                   = ex_v.lo;
    assign bus.ex_whilo                = ex_v.whilo;
    assign bus.ex_aluop                = ex_v.aluop;
    assign bus.ex_mem_addr             = ex_v.mem_addr;
    assign bus.ex_reg2                 = ex_v.reg2;
    assign bus.ex_cp0_reg_we           = ex_v.cp0_we;
    assign bus.ex_cp0_reg_write_addr   = ex_v.cp0_waddr;
    assign bus.ex_cp0_reg_data         = ex_v.cp0_data;
    assign bus.ex_excepttype           = ex_v.excepttype;
    assign bus.ex_is_in_delayslot      = ex_v.in_delayslot;
    assign bus.ex_current_inst_address = ex_v.inst_addr;
    assign bus.hilo_i                  = hilo_v;
    assign bus.cnt_i                   = cnt_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(stall[4] && !stall[3]))
            else $error("illegal stall pattern %b", stall);
    end

    task automatic cmp(input string n, input string f,
                       input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s.%s got=%h want=%h", n, f, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            out_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            cmp(n, "wd",    64'(bus.mem_wd),       64'(e.m.wd));
            cmp(n, "wreg",  64'(bus.mem_wreg),     64'(e.m.wreg));
            cmp(n, "wdata", 64'(bus.mem_wdata),    64'(e.m.wdata));
            cmp(n, "hi",    64'(bus.mem_hi),       64'(e.m.hi));
            cmp(n, "lo",    64'(bus.mem_lo),       64'(e.m.lo));
            cmp(n, "whilo", 64'(bus.mem_whilo),    64'(e.m.whilo));
            cmp(n, "aluop", 64'(bus.mem_aluop),    64'(e.m.aluop));
            cmp(n, "addr",  64'(bus.mem_mem_addr), 64'(e.m.mem_addr));
            cmp(n, "reg2",  64'(bus.mem_reg2),     64'(e.m.reg2));
            cmp(n, "cp0we", 64'(bus.mem_cp0_reg_we), 64'(e.m.cp0_we));
            cmp(n, "cp0wa", 64'(bus.mem_cp0_reg_write_addr),
                64'(e.m.cp0_waddr));
            cmp(n, "cp0d",  64'(bus.mem_cp0_reg_data), 64'(e.m.cp0_data));
            cmp(n, "exc",   64'(bus.mem_excepttype), 64'(e.m.excepttype));
            cmp(n, "ds",    64'(bus.mem_is_in_delayslot),
                64'(e.m.in_delayslot));
            cmp(n, "pc",    64'(bus.mem_current_inst_address),
                64'(e.m.inst_addr));
            cmp(n, "valid", 64'(bus.mem_valid), 64'(e.v));
            cmp(n, "hilo",  bus.hilo_o,         e.hilo);
            cmp(n, "cnt",   64'(bus.cnt_o),     64'(e.cnt));
        end
    end

    function automatic out_t o_zero();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t o_cap(input ex_mem_t e);
        out_t o;
        o      = '0;
        o.m    = e;
        o.v    = 1'b1;
        return o;
    endfunction

    function automatic out_t o_bub(input logic [63:0] h,
                                   input logic [1:0] c);
        out_t o;
        o      = '0;
        o.hilo = h;
        o.cnt  = c;
        return o;
    endfunction

    task automatic step(input string n, input logic r,
                        input logic [5:0] st, input logic fl,
                        input ex_mem_t e, input logic [63:0] h,
                        input logic [1:0] c, input out_t x);
        @(negedge clk);
        #1;
        rst    = r;
        stall  = st;
        flush  = fl;
        ex_v   = e;
        hilo_v = h;
        cnt_v  = c;
        exp_q.push_back(x);
        name_q.push_back(n);
        last = x;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_mem_t e;
        out_t    held;
        rst    = 1'b0;
        stall  = '0;
        flush  = 1'b0;
        ex_v   = '1;
        hilo_v = '1;
        cnt_v  = '1;

        e = '1;
        step("rst0", 1'b0, 6'b0, 1'b0, e, '1, 2'b11, o_zero());
        step("rst1", 1'b0, 6'b0, 1'b0, e, '1, 2'b11, o_zero());

        e = '0;
        e.wdata = 32'h12345678;
        e.wd    = 5'd5;
        e.wreg  = 1'b1;
        step("first", 1'b1, 6'b0, 1'b0, e, '0, 2'd0, o_cap(e));

        for (int i = 0; i < 4; i++) begin
            e = '0;
            e.mem_addr = 32'h100 + 32'(4 * i);
            e.aluop    = 8'h23;
            e.reg2     = 32'hC0DE0000 + 32'(i);
            step("b2b", 1'b1, 6'b0, 1'b0, e, '0, 2'd0, o_cap(e));
        end

        e = '0;
        e.wreg  = 1'b1;
        e.whilo = 1'b1;
        e.aluop = 8'h28;
        e.excepttype = 32'h400;
        step("bub", 1'b1, 6'b001111, 1'b0, e,
             64'h00000001_FFFFFFFE, 2'd1,
             o_bub(64'h00000001_FFFFFFFE, 2'd1));
        e.excepttype = 32'h0;
        e.hi = 32'h00000002;
        e.lo = 32'hFFFFFFFD;
        step("bubgo", 1'b1, 6'b0, 1'b0, e, 64'h5, 2'd2, o_cap(e));

        e = '0;
        e.wdata = 32'hAAAA5555;
        e.wreg  = 1'b1;
        e.wd    = 5'd9;
        held = o_cap(e);
        step("cap", 1'b1, 6'b0, 1'b0, e, '0, 2'd0, held);
        e.wdata = 32'h1;
        for (int i = 0; i < 3; i++)
            step("hold", 1'b1, 6'b011111, 1'b0, e,
                 64'hDEAD, 2'd3, held);

        e = '0;
        e.excepttype = 32'h200;
        e.wreg = 1'b1;
        step("cap200", 1'b1, 6'b0, 1'b0, e, '0, 2'd0, o_cap(e));
        step("flushh", 1'b1, 6'b011111, 1'b1, e, 64'h7, 2'd1, o_zero());
        step("bub2", 1'b1, 6'b001111, 1'b0, e, 64'h1234, 2'd1,
             o_bub(64'h1234, 2'd1));
        step("flushb", 1'b1, 6'b001111, 1'b1, e, 64'h9999, 2'd2,
             o_zero());

        e = '0;
        e.excepttype   = 32'h00000800;
        e.in_delayslot = 1'b1;
        e.inst_addr    = 32'hBFC00010;
        e.cp0_we       = 1'b1;
        e.cp0_waddr    = 5'd12;
        e.cp0_data     = 32'h0000FF01;
        step("exc", 1'b1, 6'b0, 1'b0, e, '0, 2'd0, o_cap(e));

        step("rststl", 1'b0, 6'b011111, 1'b0, e, 64'h3, 2'd1, o_zero());
        e = '0;
        e.wdata = 32'h0BADF00D;
        e.wd    = 5'd31;
        e.wreg  = 1'b1;
        step("rstgo", 1'b1, 6'b0, 1'b0, e, '0, 2'd0, o_cap(e));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Captures every EX result each cycle: GPR write, HI/LO write, load/store info, CP0 write and exception info.
- Handles stall bubbles and exception flush.
- Holds the 64-bit intermediate product and the 2-bit cycle counter that EX needs for two-cycle madd/maddu/msub/msubu.

Parameters:
- None. All widths come from the shared defines: RegBus 32, RegAddrBus 5, AluOpBus 8, DoubleRegBus 64.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block
- stall  in  6  pipeline stall vector from ctrl; bit3 = EX stalled, bit4 = MEM stalled
- flush  in  1  exception flush from ctrl
- ex_wd  in  5  destination GPR address
- ex_wreg  in  1  GPR write enable
- ex_wdata  in  32  GPR write data
- ex_hi, ex_lo  in  32 each  HI/LO write data
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  8  ALU op, used by MEM to decode load/store
- ex_mem_addr  in  32  load/store effective address
- ex_reg2  in  32  store data, or the old rt value for lwl/lwr
- ex_cp0_reg_we  in  1  CP0 write enable
- ex_cp0_reg_write_addr  in  5  CP0 register address
- ex_cp0_reg_data  in  32  CP0 write data
- ex_excepttype  in  32  exception flags
- ex_is_in_delayslot  in  1  instruction is in a branch delay slot
- ex_current_inst_address  in  32  PC of the instruction
- hilo_i  in  64  partial product from EX during a multi-cycle op
- cnt_i  in  2  multi-cycle op cycle count from EX
- mem_*  out  (same widths)  registered copies of every ex_* input above, 15 signals
- mem_valid  out  1  1 when a real instruction occupies MEM
- hilo_o  out  64  partial product fed back to EX
- cnt_o  out  2  cycle count fed back to EX

Behaviour:
- Single always block on posedge clk. Priority order per edge:
  1. rst==0: all outputs 0, including mem_valid, hilo_o, cnt_o.
  2. flush==1: all mem_* 0, mem_valid 0, hilo_o 0, cnt_o 0. Flush overrides stall.
  3. stall[3]==1 && stall[4]==0 (bubble): mem_* 0 and mem_valid 0. Additionally hilo_o<=hilo_i and cnt_o<=cnt_i, so the madd first-cycle product survives the stall.
  4. stall[3]==0 (advance): every mem_* <= its ex_* input, mem_valid<=1, hilo_o<=0, cnt_o<=0.
  5. Otherwise (stall[3]==1 && stall[4]==1, hold): all outputs keep their values.
- Bubble contents:
  - mem_wreg=0, mem_whilo=0, mem_cp0_reg_we=0.
  - mem_aluop = EXE_NOP_OP (8'h00).
  - mem_excepttype=0, so a bubble can never raise an exception.
- Latency: exactly one cycle from an ex_* input to the matching mem_* output when not stalled.
- Width rules:
  - Pure register transfer; no arithmetic.
  - cnt is 2 bits, driven only from cnt_i. The block never increments it.
- Illegal stall pattern: stall[4]==1 with stall[3]==0 cannot occur (ctrl stall is monotonic). The bench asserts this; RTL follows rule 4 in that case.
- Reset mid-stall: reset wins; after rst returns to 1, the first non-stalled edge captures normally.
- Flush in the same cycle as a multi-cycle op clears hilo_o/cnt_o, so EX restarts any multiply-accumulate from cnt=0.
- No combinational path from any input to any output.

Decomposition:
- defines.v, shared with all stages:
  - RstEnable = 1'b0, RstDisable = 1'b1 (active-low).
  - WriteEnable/WriteDisable, ZeroWord.
  - RegBus, RegAddrBus, AluOpBus, DoubleRegBus.
  - EXE_NOP_OP, NOPRegAddr.
- Every pipeline register in the core (if_id, id_ex, mem_wb) must use the same RstEnable polarity.
- No sub-module: a flat register stage.

Test Plan:
1. Reset: rst=0 for 2 edges with all ex_* driven to 0xFFFFFFFF → every output reads 0 and mem_valid=0. Release rst=1, stall=0, ex_wdata=0x12345678, ex_wd=5, ex_wreg=1 → next edge mem_wdata=0x12345678, mem_wd=5, mem_wreg=1, mem_valid=1.
2. Back-to-back advance: 4 consecutive instructions with ex_mem_addr 0x100, 0x104, 0x108, 0x10C → mem_mem_addr shows the same sequence, one cycle late, with no gaps.
3. Bubble with multi-cycle madd: stall=6'b001111, hilo_i=0x00000001_FFFFFFFE, cnt_i=1 → mem_wreg=0, mem_aluop=0, mem_valid=0, hilo_o=0x00000001_FFFFFFFE, cnt_o=1. Next edge with stall=0 → hilo_o=0, cnt_o=0, EX values captured.
4. Hold: capture ex_wdata=0xAAAA5555, then stall=6'b011111 for 3 cycles while ex_wdata changes to 0x1 → mem_wdata stays 0xAAAA5555 and mem_valid stays 1.
5. Flush beats stall: flush=1 together with stall=6'b011111, mem holding excepttype=0x200 → next edge all outputs 0, including hilo_o and cnt_o.
6. Exception passthrough: ex_excepttype=0x00000800, ex_is_in_delayslot=1, ex_current_inst_address=0xBFC00010, ex_cp0_reg_we=1, ex_cp0_reg_write_addr=12 → all five values appear unchanged on the mem_* outputs after one edge.
